// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM states and access decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // log2 of the access size in bytes; funct3[2] only selects zero-extension
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic funct3_legal(input logic [2:0] funct3, input logic we,
                                        input logic is64);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_D:             ok = is64;
      F3_BU, F3_HU:     ok = !we;
      F3_WU:            ok = !we && is64;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled word array with synchronous write and registered read.
// Contents are deliberately not reset.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WORD_AW = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [WORD_AW-1:0]    addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [0:(2**WORD_AW)-1];
  logic [DATA_W-1:0] rdata_r;

  // lane-masked write and registered read share one address port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_lsu.sv
// RISC-V style data-memory load/store unit: valid/ready request, funct3
// decode, alignment check, byte-lane store and extended load response.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int   LANES   = DATA_W / 8;
  localparam int   LB_W    = $clog2(LANES);
  localparam int   WORD_AW = DM_ADDRESS - LB_W;
  localparam logic IS64    = (DATA_W == 64);

  state_t            state_r, state_s;
  logic [1:0]        cnt_r, cnt_s;
  logic              rsp_valid_r;
  logic              err_r, rd_r, uns_r;
  logic [1:0]        size_r;
  logic [LB_W-1:0]   lane_r;

  logic              accept_s, err_s, misal_s;
  logic [1:0]        size_s;
  logic [LB_W-1:0]   lane_s;
  logic [7:0]        be_base_s;
  logic [LANES-1:0]  be_s;
  logic [DATA_W-1:0] wdata_s, bank_rdata_s, shifted_s, mask_s, ext_s;
  logic              sign_s;

  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign lane_s    = req_addr[LB_W-1:0];
  assign size_s    = access_size(req_funct3);
  assign wdata_s   = req_wdata << {lane_s, 3'b000};
  assign be_s      = LANES'(be_base_s << lane_s);

  // request decode: alignment, legality and store lane enables
  always_comb begin
    misal_s   = 1'b0;
    be_base_s = 8'h00;
    case (size_s)
      2'd0: begin misal_s = 1'b0;           be_base_s = 8'h01; end
      2'd1: begin misal_s = req_addr[0];    be_base_s = 8'h03; end
      2'd2: begin misal_s = |req_addr[1:0]; be_base_s = 8'h0F; end
      default: begin misal_s = |req_addr[2:0]; be_base_s = 8'hFF; end
    endcase
    err_s = !funct3_legal(req_funct3, req_we, IS64) || misal_s;
  end

  dmem_bank #(
    .DATA_W  (DATA_W),
    .WORD_AW (WORD_AW)
  ) u_bank (
    .clk   (clk),
    .we    (accept_s && req_we && !err_s),
    .be    (be_s),
    .addr  (req_addr[DM_ADDRESS-1:LB_W]),
    .wdata (wdata_s),
    .re    (accept_s && !req_we && !err_s),
    .rdata (bank_rdata_s)
  );

  // next-state logic; stores and errors skip the read-latency wait
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_we || err_s || (RD_LAT <= 1)) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
            cnt_s   = 2'(RD_LAT - 2);
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // state, response flags and load-format capture at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      rd_r        <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'd0;
      lane_r      <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rsp_valid_r <= (state_s == RESP);
      if (accept_s) begin
        err_r  <= err_s;
        rd_r   <= !req_we && !err_s;
        uns_r  <= req_funct3[2];
        size_r <= size_s;
        lane_r <= lane_s;
      end else if ((state_r == RESP) && rsp_ready) begin
        err_r <= 1'b0;
        rd_r  <= 1'b0;
      end else begin
        err_r <= err_r;
        rd_r  <= rd_r;
      end
    end
  end

  // lane extraction and sign/zero extension of the registered bank word
  always_comb begin
    shifted_s = bank_rdata_s >> {lane_r, 3'b000};
    mask_s    = '1;
    sign_s    = 1'b0;
    case (size_r)
      2'd0: begin mask_s = DATA_W'(64'h0000_0000_0000_00FF); sign_s = shifted_s[7];  end
      2'd1: begin mask_s = DATA_W'(64'h0000_0000_0000_FFFF); sign_s = shifted_s[15]; end
      2'd2: begin mask_s = DATA_W'(64'h0000_0000_FFFF_FFFF); sign_s = shifted_s[31]; end
      default: begin mask_s = '1; sign_s = 1'b0; end
    endcase
    if (sign_s && !uns_r) begin
      ext_s = (shifted_s & mask_s) | ~mask_s;
    end else begin
      ext_s = shifted_s & mask_s;
    end
  end

  // bank output is only re-read at the next acceptance, so data holds through RESP
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = (rsp_valid_r && rd_r) ? ext_s : '0;
  assign rsp_err   = rsp_valid_r && err_r;

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, meaning byte-address width (memory holds 2**DM_ADDRESS bytes).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; legal values are 32 or 64.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning load latency in cycles after acceptance; legal range is 1..4.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  meaning a request is presented.
REQ-007 SHALL have port req_ready  out  1  meaning the block can accept a request this cycle.
REQ-008 SHALL have port req_we  in  1  meaning 1 = store, 0 = load.
REQ-009 SHALL have port req_addr  in  DM_ADDRESS  meaning the byte address.
REQ-010 SHALL have port req_wdata  in  DATA_W  meaning store data, right-aligned.
REQ-011 SHALL have port req_funct3  in  3  meaning the RISC-V access size/sign code (instruction bits 14:12).
REQ-012 SHALL have port rsp_valid  out  1  meaning a response is presented.
REQ-013 SHALL have port rsp_ready  in  1  meaning the consumer accepts the response.
REQ-014 SHALL have port rsp_rdata  out  DATA_W  meaning load data, extended and right-aligned; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  meaning misaligned address or illegal funct3.

Function
REQ-016 SHALL accept a request on a cycle where req_valid && req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-017 SHALL use the FSM IDLE -> WAIT (loads only; RD_LAT-1 cycles, skipped when RD_LAT=1) -> RESP -> IDLE; an accepted store or error goes IDLE -> RESP directly.
REQ-018 SHALL hold RESP with rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-019 SHALL produce exactly one response per accepted request; a load's rsp_valid SHALL first rise RD_LAT cycles after acceptance, and a store's 1 cycle after.
REQ-020 SHALL decode funct3 as follows: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; when DATA_W=64, additionally 011 LD/SD and 110 LWU.
REQ-021 SHALL treat stores as valid only for SB/SH/SW (and SD when DATA_W=64); any other code SHALL set rsp_err.
REQ-022 SHALL flag misalignment when req_addr is not a multiple of the access size (1/2/4/8 bytes); on misalignment, memory SHALL NOT be written, rsp_err=1, and rsp_rdata=0.
REQ-023 SHALL write only the byte lanes covered by the access, selected by req_addr[log2(DATA_W/8)-1:0], with req_wdata low bytes shifted into those lanes; all other lanes SHALL be unchanged.
REQ-024 SHALL perform the store write on the acceptance edge.
REQ-025 SHALL, on a load, extract the addressed lanes and sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) them to DATA_W.
REQ-026 SHALL return stored data to a load accepted on any cycle after a store's acceptance edge, to the same or an overlapping address (no stale read).
REQ-027 SHALL ignore req_valid while not in IDLE; inputs SHALL be sampled only at acceptance.
REQ-028 SHALL use req_addr modulo 2**DM_ADDRESS, with no out-of-range error.

Reset
REQ-029 SHALL, while rst=1, set state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, and rsp_err=0; req_ready SHALL be 0 during the rst cycle.
REQ-030 SHALL, on reset mid-operation, drop a pending load response; a store already written SHALL remain written.
REQ-031 SHALL NOT reset memory contents.

Structure
REQ-032 SHALL place in package dmem_pkg: the funct3 code constants, the FSM state enum, and the access-size helper function.
REQ-033 SHALL instantiate one sub-module, dmem_bank: a byte-enabled array of DATA_W/8 lanes x 2**(DM_ADDRESS-log2(DATA_W/8)) words, with synchronous write and registered read.

Verification
REQ-034 SHALL cover: SW 0xDEADBEEF @0x010, then LW @0x010 (RD_LAT=1) -> rsp_valid 1 cycle after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 SHALL cover: SB 0x80 @0x013 onto 0x11223344, then LB @0x013 -> 0xFFFFFF80, LBU @0x013 -> 0x00000080, and LW @0x010 -> 0x80223344.
REQ-036 SHALL cover: SH 0x1234 @0x021 -> rsp_err=1 and memory @0x020 unchanged; LW @0x002 -> rsp_err=1, rsp_rdata=0.
REQ-037 SHALL cover: RD_LAT=3, LW with rsp_ready held 0 for 5 cycles -> rsp_valid rises 3 cycles after acceptance, stays stable, req_ready=0 throughout, and IDLE follows the rsp_ready edge.
REQ-038 SHALL cover: rst asserted in WAIT of a load -> no response, rsp_valid=0, and the next request is accepted normally.
REQ-039 SHALL cover: DATA_W=64, SD 0x0123456789ABCDEF @0x008, then LWU @0x00C -> 0x0000000001234567.
